// File: rtl/tl_updatefc_scheduler.sv
// Rx credit-return scheduler: accumulates freed P/NP/CPL credits and issues round-robin UpdateFC requests.
// Optional build macro UPDATEFC_REFRESH_EN: timer expiry makes every type due, allowing zero-increment keep-alives.
module tl_updatefc_scheduler #(
    parameter int CNT_W        = 12,
    parameter int HDR_THRESH   = 4,
    parameter int DATA_THRESH  = 16,
    parameter int UPDATE_TIMER = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             link_active_i,
    input  logic             p_hdr_rden_i,
    input  logic             p_data_rden_i,
    input  logic             np_hdr_rden_i,
    input  logic             cpl_hdr_rden_i,
    input  logic             cpl_data_rden_i,
    output logic             upd_valid_o,
    output logic [1:0]       upd_type_o,
    output logic [CNT_W-1:0] upd_hdr_o,
    output logic [CNT_W-1:0] upd_data_o,
    input  logic             upd_ready_i,
    output logic [2:0]       pending_o
);

    localparam int TW = (UPDATE_TIMER > 1) ? $clog2(UPDATE_TIMER) : 1;
    localparam logic [TW-1:0]    TIMER_LAST = TW'(UPDATE_TIMER - 1);
    localparam logic [CNT_W-1:0] HDR_TH     = CNT_W'(HDR_THRESH);
    localparam logic [CNT_W-1:0] DATA_TH    = CNT_W'(DATA_THRESH);
    localparam logic [1:0] T_P   = 2'd0;
    localparam logic [1:0] T_NP  = 2'd1;
    localparam logic [1:0] T_CPL = 2'd2;

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  hd_p_q, hd_p_d, hd_np_q, hd_np_d, hd_cpl_q, hd_cpl_d;
    logic [CNT_W-1:0]  dd_p_q, dd_p_d, dd_cpl_q, dd_cpl_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [2:0]        due_q, due_d;
    logic [1:0]        rr_q, rr_d;
    logic              upd_valid_q, upd_valid_d;
    logic [1:0]        upd_type_q, upd_type_d;
    logic [CNT_W-1:0]  upd_hdr_q, upd_hdr_d;
    logic [CNT_W-1:0]  upd_data_q, upd_data_d;

    logic              hs;
    logic              expire;
    logic [2:0]        pending;
    logic [2:0]        sent_mask;
    logic [2:0]        nonzero;
    logic [2:0]        due_set;
    logic              grant_found;
    logic [1:0]        grant_type;
    logic [CNT_W-1:0]  sent_hd_p, sent_hd_np, sent_hd_cpl, sent_dd_p, sent_dd_cpl;

    // The subtracted payload was latched from this counter, so old + inc - sent never underflows.
    function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] old_v,
                                                  input logic [1:0]       inc_v,
                                                  input logic [CNT_W-1:0] sent_v);
        logic [CNT_W+1:0] sum;
        sum = {2'b00, old_v} + {{CNT_W{1'b0}}, inc_v} - {2'b00, sent_v};
        if (sum > {2'b00, {CNT_W{1'b1}}}) begin
            return {CNT_W{1'b1}};
        end
        return sum[CNT_W-1:0];
    endfunction

    always_comb begin
        pending[0] = (hd_p_q >= HDR_TH) | (dd_p_q >= DATA_TH) | due_q[0];
        pending[1] = (hd_np_q >= HDR_TH) | due_q[1];
        pending[2] = (hd_cpl_q >= HDR_TH) | (dd_cpl_q >= DATA_TH) | due_q[2];
    end

    always_comb begin
        grant_found = 1'b0;
        grant_type  = T_P;
        for (int i = 0; i < 3; i++) begin
            int idx;
            idx = int'(rr_q) + i;
            if (idx >= 3) idx = idx - 3;
            if (!grant_found && pending[idx]) begin
                grant_found = 1'b1;
                grant_type  = 2'(idx);
            end
        end
    end

    always_comb begin
        hs        = upd_valid_q & upd_ready_i;
        sent_mask = 3'b000;
        if (hs) sent_mask[upd_type_q] = 1'b1;

        sent_hd_p   = sent_mask[0] ? upd_hdr_q  : '0;
        sent_dd_p   = sent_mask[0] ? upd_data_q : '0;
        sent_hd_np  = sent_mask[1] ? upd_hdr_q  : '0;
        sent_hd_cpl = sent_mask[2] ? upd_hdr_q  : '0;
        sent_dd_cpl = sent_mask[2] ? upd_data_q : '0;

        hd_p_d   = next_cnt(hd_p_q,   {1'b0, p_hdr_rden_i},    sent_hd_p);
        dd_p_d   = next_cnt(dd_p_q,   {p_data_rden_i, 1'b0},   sent_dd_p);
        hd_np_d  = next_cnt(hd_np_q,  {1'b0, np_hdr_rden_i},   sent_hd_np);
        hd_cpl_d = next_cnt(hd_cpl_q, {1'b0, cpl_hdr_rden_i},  sent_hd_cpl);
        dd_cpl_d = next_cnt(dd_cpl_q, {cpl_data_rden_i, 1'b0}, sent_dd_cpl);

        expire  = (timer_q == TIMER_LAST);
        timer_d = expire ? '0 : timer_q + 1'b1;

        // Judge "nonzero" on the post-update value so a type sent this cycle is not re-armed empty.
        nonzero[0] = (hd_p_d != '0) | (dd_p_d != '0);
        nonzero[1] = (hd_np_d != '0);
        nonzero[2] = (hd_cpl_d != '0) | (dd_cpl_d != '0);
`ifdef UPDATEFC_REFRESH_EN
        due_set = expire ? 3'b111 : 3'b000;
`else
        due_set = expire ? nonzero : 3'b000;
`endif
        due_d = (due_q & ~sent_mask) | due_set;

        state_d     = state_q;
        rr_d        = rr_q;
        upd_valid_d = upd_valid_q;
        upd_type_d  = upd_type_q;
        upd_hdr_d   = upd_hdr_q;
        upd_data_d  = upd_data_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    state_d     = ST_SEND;
                    upd_valid_d = 1'b1;
                    upd_type_d  = grant_type;
                    case (grant_type)
                        T_P: begin
                            upd_hdr_d  = hd_p_q;
                            upd_data_d = dd_p_q;
                        end
                        T_NP: begin
                            upd_hdr_d  = hd_np_q;
                            upd_data_d = '0;
                        end
                        default: begin
                            upd_hdr_d  = hd_cpl_q;
                            upd_data_d = dd_cpl_q;
                        end
                    endcase
                end
            end
            ST_SEND: begin
                if (hs) begin
                    state_d     = ST_IDLE;
                    upd_valid_d = 1'b0;
                    rr_d        = (upd_type_q == T_CPL) ? T_P : upd_type_q + 2'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                upd_valid_d = 1'b0;
            end
        endcase

        // Link down discards everything in flight; only the arbitration pointer survives.
        if (!link_active_i) begin
            hd_p_d      = '0;
            dd_p_d      = '0;
            hd_np_d     = '0;
            hd_cpl_d    = '0;
            dd_cpl_d    = '0;
            timer_d     = '0;
            due_d       = '0;
            state_d     = ST_IDLE;
            upd_valid_d = 1'b0;
            upd_type_d  = '0;
            upd_hdr_d   = '0;
            upd_data_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hd_p_q      <= '0;
            dd_p_q      <= '0;
            hd_np_q     <= '0;
            hd_cpl_q    <= '0;
            dd_cpl_q    <= '0;
            timer_q     <= '0;
            due_q       <= '0;
            rr_q        <= T_P;
            upd_valid_q <= 1'b0;
            upd_type_q  <= '0;
            upd_hdr_q   <= '0;
            upd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            hd_p_q      <= hd_p_d;
            dd_p_q      <= dd_p_d;
            hd_np_q     <= hd_np_d;
            hd_cpl_q    <= hd_cpl_d;
            dd_cpl_q    <= dd_cpl_d;
            timer_q     <= timer_d;
            due_q       <= due_d;
            rr_q        <= rr_d;
            upd_valid_q <= upd_valid_d;
            upd_type_q  <= upd_type_d;
            upd_hdr_q   <= upd_hdr_d;
            upd_data_q  <= upd_data_d;
        end
    end

    assign upd_valid_o = upd_valid_q;
    assign upd_type_o  = upd_type_q;
    assign upd_hdr_o   = upd_hdr_q;
    assign upd_data_o  = upd_data_q;
    assign pending_o   = pending;

endmodule
